// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: prioritises jumps, holds and load-use hazards
// into pc redirect, stall and flush controls, with a sticky hold watchdog.
//
// state | meaning
// RUN   | normal issue; jump, hold and load-use requests are arbitrated
// FLUSH | bubbles from a taken jump still draining; only a new jump acts
// HOLD  | pipeline frozen by an execute or bus hold
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned HOLD_MAX     = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  input  logic        ext_hold_i,
  input  logic        load_use_i,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic        stall_pc_o,
  output logic        stall_if_id_o,
  output logic        stall_id_ex_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic [1:0]  state_o,
  output logic        hold_timeout_o
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [3:0] FLUSH_RELOAD = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;
  localparam logic [1:0] JUMP_NEXT    = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
  localparam logic [7:0] HOLD_LIMIT   = 8'(HOLD_MAX);

  logic [1:0] state, state_nxt;
  logic [3:0] flush_cnt, flush_cnt_nxt;
  logic [7:0] hold_cnt, hold_cnt_nxt;
  logic       timeout_q, timeout_nxt;
  logic       hold_req;

  assign hold_req = hold_flag_i | ext_hold_i;

  // HOLD arbitrates exactly like RUN; it only differs in what state_o reports.
  always_comb begin
    jump_en_o     = 1'b0;
    jump_addr_o   = 32'd0;
    stall_pc_o    = 1'b0;
    stall_if_id_o = 1'b0;
    stall_id_ex_o = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    hold_cnt_nxt  = hold_cnt;
    timeout_nxt   = timeout_q;

    if (rst) begin
      flush_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
    end else if (jump_en_i) begin
      jump_en_o     = 1'b1;
      jump_addr_o   = jump_addr_i;
      flush_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
      state_nxt     = JUMP_NEXT;
      flush_cnt_nxt = FLUSH_RELOAD;
      hold_cnt_nxt  = 8'd0;
    end else if (state == ST_FLUSH) begin
      flush_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
      if (flush_cnt == 4'd0) begin
        state_nxt = ST_RUN;
      end else begin
        flush_cnt_nxt = flush_cnt - 4'd1;
      end
    end else if (hold_req) begin
      stall_pc_o    = 1'b1;
      stall_if_id_o = 1'b1;
      stall_id_ex_o = 1'b1;
      state_nxt     = ST_HOLD;
      hold_cnt_nxt  = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
      if (hold_cnt_nxt >= HOLD_LIMIT) begin
        timeout_nxt = 1'b1;
      end
    end else begin
      state_nxt    = ST_RUN;
      hold_cnt_nxt = 8'd0;
      if (load_use_i) begin
        stall_pc_o    = 1'b1;
        stall_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
      end
    end
  end

  always_comb begin
    if (rst || (state == ST_HOLD && !hold_req)) begin
      state_o = ST_RUN;
    end else begin
      state_o = state;
    end
  end

  assign hold_timeout_o = timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      flush_cnt <= 4'd0;
      hold_cnt  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      hold_cnt  <= hold_cnt_nxt;
      timeout_q <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: a cycle-level model of bubbles owed and consecutive
// held cycles is compared every cycle, plus directed literal expectations.
module tb_pipe_ctrl;

  localparam int FC = 2;
  localparam int HM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_en_i = 1'b0;
  logic [31:0] jump_addr_i = 32'd0;
  logic        hold_flag_i = 1'b0;
  logic        ext_hold_i = 1'b0;
  logic        load_use_i = 1'b0;
  logic        jump_en_o;
  logic [31:0] jump_addr_o;
  logic        stall_pc_o, stall_if_id_o, stall_id_ex_o;
  logic        flush_if_id_o, flush_id_ex_o;
  logic [1:0]  state_o;
  logic        hold_timeout_o;

  int errors = 0;
  int checks = 0;

  pipe_ctrl #(.FLUSH_CYCLES(FC), .HOLD_MAX(HM)) dut (
    .clk(clk), .rst(rst),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .hold_flag_i(hold_flag_i), .ext_hold_i(ext_hold_i), .load_use_i(load_use_i),
    .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o),
    .stall_pc_o(stall_pc_o), .stall_if_id_o(stall_if_id_o), .stall_id_ex_o(stall_id_ex_o),
    .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o),
    .state_o(state_o), .hold_timeout_o(hold_timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bubbles still owed after the current cycle, consecutive held cycles.
  int m_bubbles = 0;
  int m_held = 0;
  bit m_holding = 1'b0;
  bit m_timeout = 1'b0;
  bit chk_en = 1'b0;

  always @(posedge clk) begin
    chk_en = 1'b1;
    if (rst) begin
      m_bubbles = 0; m_held = 0; m_holding = 1'b0; m_timeout = 1'b0;
    end else if (jump_en_i) begin
      m_bubbles = FC - 1; m_held = 0; m_holding = 1'b0;
    end else if (m_bubbles > 0) begin
      m_bubbles--;
    end else if (hold_flag_i || ext_hold_i) begin
      if (m_held < 255) m_held++;
      if (m_held >= HM) m_timeout = 1'b1;
      m_holding = 1'b1;
    end else begin
      m_held = 0; m_holding = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic        e_jump;
    logic [31:0] e_addr;
    logic [2:0]  e_stall;
    logic [1:0]  e_flush;
    logic [1:0]  e_state;
    bit          hold_now;
    if (chk_en) begin
      hold_now = hold_flag_i || ext_hold_i;
      e_jump = 1'b0; e_addr = 32'd0; e_stall = 3'b000; e_flush = 2'b00;
      if (rst) e_flush = 2'b11;
      else if (jump_en_i) begin e_jump = 1'b1; e_addr = jump_addr_i; e_flush = 2'b11; end
      else if (m_bubbles > 0) e_flush = 2'b11;
      else if (hold_now) e_stall = 3'b111;
      else if (load_use_i) begin e_stall = 3'b110; e_flush = 2'b01; end
      if (rst) e_state = 2'd0;
      else if (m_bubbles > 0) e_state = 2'd1;
      else if (m_holding && hold_now) e_state = 2'd2;
      else e_state = 2'd0;
      check("jump_en", 32'(jump_en_o), 32'(e_jump));
      check("jump_addr", jump_addr_o, e_addr);
      check("stalls", 32'({stall_pc_o, stall_if_id_o, stall_id_ex_o}), 32'(e_stall));
      check("flushes", 32'({flush_if_id_o, flush_id_ex_o}), 32'(e_flush));
      check("state", 32'(state_o), 32'(e_state));
      check("timeout", 32'(hold_timeout_o), 32'(m_timeout));
      check("no_stall_and_flush",
            32'((stall_if_id_o & flush_if_id_o) | (stall_id_ex_o & flush_id_ex_o)), 32'd0);
    end
  end

  // Apply one cycle of inputs just after the edge, then stop at mid-cycle.
  task automatic drive(input logic r, input logic j, input logic [31:0] a,
                       input logic hf, input logic eh, input logic lu);
    @(posedge clk);
    #1;
    rst = r; jump_en_i = j; jump_addr_i = a;
    hold_flag_i = hf; ext_hold_i = eh; load_use_i = lu;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset
    drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    check("rst_flush", 32'({flush_if_id_o, flush_id_ex_o}), 32'h3);
    check("rst_state", 32'(state_o), 32'd0);
    drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    idle();
    check("idle_all", 32'({jump_en_o, stall_pc_o, stall_if_id_o, stall_id_ex_o,
                           flush_if_id_o, flush_id_ex_o, hold_timeout_o}), 32'd0);

    // Single jump
    drive(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    check("j1_addr", jump_addr_o, 32'h40);
    check("j1_en", 32'(jump_en_o), 32'd1);
    idle();
    check("j1_state_flush", 32'(state_o), 32'd1);
    check("j1_flush2", 32'({flush_if_id_o, flush_id_ex_o}), 32'h3);
    idle();
    check("j1_done", 32'({state_o, flush_if_id_o, flush_id_ex_o}), 32'd0);

    // Jump restarting the flush window; hold ignored while flushing
    drive(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
    check("j2_addr", jump_addr_o, 32'h80);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    check("j2_tail_noflush_stall", 32'({stall_pc_o, flush_if_id_o}), 32'b01);
    idle();
    check("j2_done_state", 32'(state_o), 32'd0);

    // Short hold
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      check("h3_stalls", 32'({stall_pc_o, stall_if_id_o, stall_id_ex_o}), 32'h7);
      check("h3_state", 32'(state_o), (i == 0) ? 32'd0 : 32'd2);
    end
    idle();
    check("h3_release", 32'({state_o, stall_pc_o}), 32'd0);
    check("h3_no_timeout", 32'(hold_timeout_o), 32'd0);

    // Watchdog with HOLD_MAX=4
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
      check("wd_flag", 32'(hold_timeout_o), (i >= 4) ? 32'd1 : 32'd0);
    end
    idle();
    idle();
    check("wd_sticky", 32'(hold_timeout_o), 32'd1);

    // Priorities
    drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    check("pri_hold", 32'({stall_pc_o, stall_if_id_o, stall_id_ex_o, flush_if_id_o, flush_id_ex_o}), 32'b11100);
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    check("pri_lu", 32'({stall_pc_o, stall_if_id_o, stall_id_ex_o, flush_if_id_o, flush_id_ex_o}), 32'b11001);
    check("pri_lu_state", 32'(state_o), 32'd0);
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 32'hC0, 1'b0, 1'b0, 1'b1);
    check("pri_jump", 32'({stall_pc_o, stall_if_id_o, stall_id_ex_o, flush_if_id_o, flush_id_ex_o}), 32'b00011);
    idle();
    idle();

    // Jump taken out of HOLD
    drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    check("hold_jump_addr", jump_addr_o, 32'h100);
    drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    check("hold_jump_flush_state", 32'(state_o), 32'd1);
    drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    idle();

    // Reset clears the watchdog
    drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    idle();
    check("rst_clears_timeout", 32'(hold_timeout_o), 32'd0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
